pit_table: RTL

//  Pending Interest Table of the NDN router; neighbour stage of the FIB.

---
 rtl/ndn_pkg.sv | 34 +++
 rtl/pit_table_if.sv | 37 +++
 rtl/pit_match.sv | 25 ++
 rtl/pit_table.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ndn_pkg.sv
// Shared widths, PIT entry layout, FSM state types and the priority encoder used by the PIT.
package ndn_pkg;

  localparam int unsigned PREFIX_W  = 64;
  localparam int unsigned LEN_W     = 6;
  localparam int unsigned BYTE_W    = 8;
  // Upper bound on router faces; entries store masks at this width.
  localparam int unsigned FACES_MAX = 16;

  typedef struct packed {
    logic                 valid;
    logic                 busy;
    logic [PREFIX_W-1:0]  prefix;
    logic [LEN_W-1:0]     len;
    logic [FACES_MAX-1:0] faces;
  } pit_entry_t;

  typedef enum logic [1:0] {StIIdle, StILook, StIFwd} int_state_e;
  typedef enum logic [1:0] {StDIdle, StDLook, StDResp, StDXfer} data_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int unsigned prio_idx(input logic [63:0] vec);
    logic found;
    found    = 1'b0;
    prio_idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (vec[i] && !found) begin
        prio_idx = i;
        found    = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/pit_table_if.sv
// Interest, FIB and face-side signals of the PIT; slave modport is the PIT itself.
interface pit_table_if import ndn_pkg::*; #(
  parameter int unsigned FACES = 4
) ();
  logic                int_valid;
  logic                int_ready;
  logic [PREFIX_W-1:0] int_prefix;
  logic [LEN_W-1:0]    int_len;
  logic [FACES-1:0]    int_face;
  logic                int_nack;
  logic [PREFIX_W-1:0] pit_in_prefix;
  logic [LEN_W-1:0]    pit_in_len;
  logic                fib_out_bit;
  logic [PREFIX_W-1:0] pit_out_prefix;
  logic [LEN_W-1:0]    pit_out_len;
  logic                prefix_ready;
  logic                start_send_to_pit;
  logic                rejected;
  logic [BYTE_W-1:0]   out_data;
  logic                face_valid;
  logic [BYTE_W-1:0]   face_data;
  logic [FACES-1:0]    face_mask;

  modport slave (
    input  int_valid, int_prefix, int_len, int_face, pit_out_prefix, pit_out_len,
           prefix_ready, out_data,
    output int_ready, int_nack, pit_in_prefix, pit_in_len, fib_out_bit, start_send_to_pit,
           rejected, face_valid, face_data, face_mask
  );

  modport master (
    output int_valid, int_prefix, int_len, int_face, pit_out_prefix, pit_out_len,
           prefix_ready, out_data,
    input  int_ready, int_nack, pit_in_prefix, pit_in_len, fib_out_bit, start_send_to_pit,
           rejected, face_valid, face_data, face_mask
  );
endinterface

// File: rtl/pit_match.sv
// DEPTH-way exact prefix/length comparator over idle, valid entries; lowest index wins.
module pit_match import ndn_pkg::*; #(
  parameter int unsigned DEPTH = 16
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [DEPTH-1:0]         busy,
  input  logic [PREFIX_W-1:0]      prefixes [DEPTH],
  input  logic [LEN_W-1:0]         lens [DEPTH],
  input  logic [PREFIX_W-1:0]      prefix,
  input  logic [LEN_W-1:0]         len,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] idx
);
  logic [63:0] match_v;

  always_comb begin
    match_v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_v[i] = valid[i] && !busy[i] && (lens[i] == len) && (prefixes[i] == prefix);
    end
  end

  assign hit = |match_v;
  assign idx = $clog2(DEPTH)'(prio_idx(match_v));
endmodule

// File: rtl/pit_table.sv
// NDN Pending Interest Table: aggregates interests, forwards new prefixes to the FIB and streams
// satisfying data to the requesting faces. Define PIT_TIMEOUT_EN for per-entry lifetimes.
module pit_table import ndn_pkg::*; #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FACES      = 4,
  parameter int unsigned DATA_BYTES = 1024,
  parameter int unsigned LIFETIME   = 4096
) (
  input logic        clk,
  input logic        rst,
  pit_table_if.slave bus
);
  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DATA_BYTES + 1);
  localparam logic [CntW-1:0] LastByte = CntW'(DATA_BYTES - 1);

  if (DEPTH < 2 || DEPTH > 64 || FACES > FACES_MAX || LIFETIME < 2) begin : g_param_check
    $error("pit_table: unsupported parameter set");
  end

  pit_entry_t          tab_q [DEPTH];
  logic [DEPTH-1:0]    valid_v, busy_v;
  logic [PREFIX_W-1:0] pfx_a [DEPTH];
  logic [LEN_W-1:0]    len_a [DEPTH];
  logic [63:0]         free_v;
  logic                free_hit, i_hit, d_hit;
  logic [IdxW-1:0]     free_idx, i_idx, d_idx;
  logic                i_agg, i_alloc, d_set, d_clr;

  int_state_e          ist_q;
  logic                int_ready_q, int_nack_q, fib_q;
  logic [PREFIX_W-1:0] pin_prefix_q, ip_q;
  logic [LEN_W-1:0]    pin_len_q, il_q;
  logic [FACES-1:0]    if_q;

  data_state_e         dst_q;
  logic [PREFIX_W-1:0] dp_q;
  logic [LEN_W-1:0]    dl_q;
  logic                dhit_q, start_q, rej_q, fv_q;
  logic [IdxW-1:0]     didx_q;
  logic [FACES-1:0]    mask_q;
  logic [BYTE_W-1:0]   fd_q;
  logic [CntW-1:0]     cnt_q;

  always_comb begin
    valid_v = '0;
    busy_v  = '0;
    free_v  = '0;
    pfx_a   = '{default: '0};
    len_a   = '{default: '0};
    for (int i = 0; i < DEPTH; i++) begin
      valid_v[i] = tab_q[i].valid;
      busy_v[i]  = tab_q[i].busy;
      pfx_a[i]   = tab_q[i].prefix;
      len_a[i]   = tab_q[i].len;
      free_v[i]  = !tab_q[i].valid && !tab_q[i].busy;
    end
  end

  assign free_hit = |free_v;
  assign free_idx = IdxW'(prio_idx(free_v));

  pit_match #(.DEPTH(DEPTH)) u_int_match (
    .valid    (valid_v),
    .busy     (busy_v),
    .prefixes (pfx_a),
    .lens     (len_a),
    .prefix   (ip_q),
    .len      (il_q),
    .hit      (i_hit),
    .idx      (i_idx)
  );

  pit_match #(.DEPTH(DEPTH)) u_data_match (
    .valid    (valid_v),
    .busy     (busy_v),
    .prefixes (pfx_a),
    .lens     (len_a),
    .prefix   (dp_q),
    .len      (dl_q),
    .hit      (d_hit),
    .idx      (d_idx)
  );

  // A data lookup claiming the same entry this cycle takes precedence over aggregation.
  assign i_agg   = (ist_q == StILook) && i_hit &&
                   !((dst_q == StDLook) && d_hit && (d_idx == i_idx));
  assign i_alloc = (ist_q == StILook) && !i_agg && free_hit;
  assign d_set   = (dst_q == StDLook) && d_hit;
  assign d_clr   = (dst_q == StDXfer) && (cnt_q == LastByte);

`ifdef PIT_TIMEOUT_EN
  localparam int unsigned LifeW = $clog2(LIFETIME);
  logic [LifeW-1:0] life_q [DEPTH];
`endif

  // Statement order encodes priority: expiry, then data clear/busy-set, then interest writes.
  always_ff @(posedge clk) begin : p_table
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tab_q[i] <= '0;
`ifdef PIT_TIMEOUT_EN
        life_q[i] <= '0;
`endif
      end
    end else begin
`ifdef PIT_TIMEOUT_EN
      for (int i = 0; i < DEPTH; i++) begin
        if (tab_q[i].valid && !tab_q[i].busy) begin
          if (life_q[i] == '0) tab_q[i].valid <= 1'b0;
          else                 life_q[i] <= life_q[i] - LifeW'(1);
        end
      end
`endif
      if (d_clr) begin
        tab_q[didx_q].valid <= 1'b0;
        tab_q[didx_q].busy  <= 1'b0;
      end
      if (d_set) tab_q[d_idx].busy <= 1'b1;
      if (i_agg) begin
        tab_q[i_idx].valid <= 1'b1;
        tab_q[i_idx].faces <= tab_q[i_idx].faces | FACES_MAX'(if_q);
`ifdef PIT_TIMEOUT_EN
        life_q[i_idx] <= LifeW'(LIFETIME - 1);
`endif
      end
      if (i_alloc) begin
        tab_q[free_idx] <= '{valid: 1'b1, busy: 1'b0, prefix: ip_q, len: il_q,
                             faces: FACES_MAX'(if_q)};
`ifdef PIT_TIMEOUT_EN
        life_q[free_idx] <= LifeW'(LIFETIME - 1);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin : p_int_fsm
    if (rst) begin
      ist_q        <= StIIdle;
      int_ready_q  <= 1'b1;
      int_nack_q   <= 1'b0;
      fib_q        <= 1'b0;
      pin_prefix_q <= '0;
      pin_len_q    <= '0;
      ip_q         <= '0;
      il_q         <= '0;
      if_q         <= '0;
    end else begin
      int_nack_q <= 1'b0;
      fib_q      <= 1'b0;
      case (ist_q)
        StIIdle: begin
          if (bus.int_valid && int_ready_q) begin
            ip_q        <= bus.int_prefix;
            il_q        <= bus.int_len;
            if_q        <= bus.int_face;
            int_ready_q <= 1'b0;
            ist_q       <= StILook;
          end
        end
        StILook: begin
          if (i_agg) begin
            int_ready_q <= 1'b1;
            ist_q       <= StIIdle;
          end else if (free_hit) begin
            fib_q        <= 1'b1;
            pin_prefix_q <= ip_q;
            pin_len_q    <= il_q;
            ist_q        <= StIFwd;
          end else begin
            int_nack_q  <= 1'b1;
            int_ready_q <= 1'b1;
            ist_q       <= StIIdle;
          end
        end
        StIFwd: begin
          int_ready_q <= 1'b1;
          ist_q       <= StIIdle;
        end
        default: begin
          int_ready_q <= 1'b1;
          ist_q       <= StIIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin : p_data_fsm
    if (rst) begin
      dst_q   <= StDIdle;
      dp_q    <= '0;
      dl_q    <= '0;
      dhit_q  <= 1'b0;
      didx_q  <= '0;
      mask_q  <= '0;
      start_q <= 1'b0;
      rej_q   <= 1'b0;
      fv_q    <= 1'b0;
      fd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (dst_q)
        StDIdle: begin
          if (bus.prefix_ready) begin
            dp_q  <= bus.pit_out_prefix;
            dl_q  <= bus.pit_out_len;
            dst_q <= StDLook;
          end
        end
        StDLook: begin
          dhit_q  <= d_hit;
          didx_q  <= d_idx;
          start_q <= d_hit;
          rej_q   <= !d_hit;
          if (d_hit) mask_q <= FACES'(tab_q[d_idx].faces);
          dst_q   <= StDResp;
        end
        StDResp: begin
          start_q <= 1'b0;
          rej_q   <= 1'b0;
          if (dhit_q) begin
            fv_q  <= 1'b1;
            fd_q  <= bus.out_data;
            cnt_q <= '0;
            dst_q <= StDXfer;
          end else begin
            dst_q <= StDIdle;
          end
        end
        StDXfer: begin
          if (cnt_q == LastByte) begin
            fv_q   <= 1'b0;
            mask_q <= '0;
            dst_q  <= StDIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
            fd_q  <= bus.out_data;
          end
        end
        default: dst_q <= StDIdle;
      endcase
    end
  end

  assign bus.int_ready         = int_ready_q;
  assign bus.int_nack          = int_nack_q;
  assign bus.pit_in_prefix     = pin_prefix_q;
  assign bus.pit_in_len        = pin_len_q;
  assign bus.fib_out_bit       = fib_q;
  assign bus.start_send_to_pit = start_q;
  assign bus.rejected          = rej_q;
  assign bus.face_valid        = fv_q;
  assign bus.face_data         = fd_q;
  assign bus.face_mask         = mask_q;
endmodule
